// File: rtl/c3lib_ckmux4_sel_seq.sv
// Select sequencer for the 4:1 clock mux: gates downstream clock off, waits, switches {s1,s0}, settles, re-enables.
// Optional input synchronizers on sel_req_vld/tst_override: define C3LIB_CKMUX4_SEL_SEQ_SYNC_EN.
module c3lib_ckmux4_sel_seq #(
    parameter int          GATE_CYC   = 4,
    parameter int          SETTLE_CYC = 4,
    parameter int          CNT_W      = 4,
    parameter logic [1:0]  RST_SEL    = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel_req,
    input  logic       sel_req_vld,
    output logic       sel_req_rdy,
    input  logic       tst_override,
    output logic       s0,
    output logic       s1,
    output logic       ck_gate_en,
    output logic       sel_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GATE_OFF = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Counter loads hold the cycle count minus one so a load of zero means one cycle.
    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       sel_r;
    logic [1:0]       req_q_r;
    logic             gate_en_r;
    logic             done_r;
    logic             busy_r;
    logic             vld_s;
    logic             ovr_s;
    logic             accept_s;

`ifdef C3LIB_CKMUX4_SEL_SEQ_SYNC_EN
    logic [1:0] vld_sync_r;
    logic [1:0] ovr_sync_r;

    // Two-flop synchronizers for the asynchronous request valid and test freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sync_r <= 2'b00;
            ovr_sync_r <= 2'b00;
        end else begin
            vld_sync_r <= {vld_sync_r[0], sel_req_vld};
            ovr_sync_r <= {ovr_sync_r[0], tst_override};
        end
    end

    assign vld_s = vld_sync_r[1];
    assign ovr_s = ovr_sync_r[1];
`else
    assign vld_s = sel_req_vld;
    assign ovr_s = tst_override;
`endif

    assign sel_req_rdy = (state_r == ST_IDLE) & ~ovr_s;
    assign accept_s    = vld_s & sel_req_rdy;

    // Sequencer FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            sel_r     <= RST_SEL;
            req_q_r   <= RST_SEL;
            gate_en_r <= 1'b1;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else if (ovr_s) begin
            // Freeze: everything holds, but no completion pulse may escape.
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        req_q_r <= sel_req;
                        busy_r  <= 1'b1;
                        if (sel_req == sel_r) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r   <= ST_GATE_OFF;
                            cnt_r     <= GATE_LD;
                            gate_en_r <= 1'b0;
                        end
                    end
                end
                ST_GATE_OFF: begin
                    if (cnt_r == CNT_ZERO) begin
                        sel_r   <= req_q_r;
                        cnt_r   <= SETTLE_LD;
                        state_r <= ST_SETTLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == CNT_ZERO) begin
                        gate_en_r <= 1'b1;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= CNT_ZERO;
                    gate_en_r <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign s1         = sel_r[1];
    assign s0         = sel_r[0];
    assign ck_gate_en = gate_en_r;
    assign sel_done   = done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_c3lib_ckmux4_sel_seq.sv
// Self-checking bench for c3lib_ckmux4_sel_seq: directed scenarios plus random traffic against a phase-count model.
module tb_c3lib_ckmux4_sel_seq;

    localparam int         G    = 4;
    localparam int         S    = 4;
    localparam logic [1:0] RSEL = 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel_req = 2'b00;
    logic       sel_req_vld = 1'b0;
    logic       tst_override = 1'b0;
    logic       sel_req_rdy, s0, s1, ck_gate_en, sel_done, busy;

    int n_tot = 0;
    int n_bad = 0;

    // Model: ph counts active edges since accept (0 = idle).
    int         ph = 0;
    logic       same = 1'b0;
    logic [1:0] cur_sel = RSEL;
    logic [1:0] tgt_sel = RSEL;
    logic       exp_done = 1'b0;
    logic       edge_rst = 1'b0;
    logic [1:0] prev_sel = RSEL;
    logic       prev_gate = 1'b1;

    c3lib_ckmux4_sel_seq #(
        .GATE_CYC(G), .SETTLE_CYC(S), .CNT_W(4), .RST_SEL(RSEL)
    ) dut (
        .clk(clk), .rst(rst), .sel_req(sel_req), .sel_req_vld(sel_req_vld),
        .sel_req_rdy(sel_req_rdy), .tst_override(tst_override),
        .s0(s0), .s1(s1), .ck_gate_en(ck_gate_en), .sel_done(sel_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge, using the inputs as they stand at that edge.
    task automatic model_edge();
        edge_rst = rst;
        exp_done = 1'b0;
        if (rst) begin
            ph = 0;
            cur_sel = RSEL;
        end else if (!tst_override) begin
            if (ph == 0) begin
                if (sel_req_vld) begin
                    tgt_sel = sel_req;
                    same    = (sel_req == cur_sel);
                    ph      = 1;
                end
            end else begin
                ph = ph + 1;
                if (same) begin
                    if (ph == 2) begin
                        exp_done = 1'b1;
                        ph = 0;
                    end
                end else begin
                    if (ph == G + 1) cur_sel = tgt_sel;
                    if (ph == G + S + 1) begin
                        exp_done = 1'b1;
                        ph = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        logic exp_gate;
        exp_gate = !(ph != 0 && !same);
        check_eq("sel", int'({s1, s0}), int'(cur_sel));
        check_eq("gate", int'(ck_gate_en), int'(exp_gate));
        check_eq("done", int'(sel_done), int'(exp_done));
        check_eq("busy", int'(busy), int'(ph != 0));
        check_eq("rdy", int'(sel_req_rdy), int'(ph == 0 && !tst_override));
        if (!edge_rst && {s1, s0} != prev_sel)
            check_eq("sel_chg_gated", int'(prev_gate | ck_gate_en), 0);
        prev_sel  = {s1, s0};
        prev_gate = ck_gate_en;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic issue(input logic [1:0] r);
        sel_req     = r;
        sel_req_vld = 1'b1;
        step();
        sel_req_vld = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sel_done && n < 40);
        if (!sel_done) check_eq("done_timeout", 0, 1);
    endtask

    initial begin
        int n;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("rst_sel", int'({s1, s0}), 0);
        check_eq("rst_gate", int'(ck_gate_en), 1);

        // Different select: full gate/settle sequence.
        issue(2'b10);
        wait_done(n);
        check_eq("lat_switch", n, G + S);
        check_eq("sel_10", int'({s1, s0}), 2);

        // Same select: quick completion, no gating.
        issue(2'b10);
        wait_done(n);
        check_eq("lat_same", n, 1);

        // Request while busy is ignored.
        issue(2'b11);
        step();
        step();
        sel_req = 2'b01;
        sel_req_vld = 1'b1;
        repeat (3) step();
        sel_req_vld = 1'b0;
        wait_done(n);
        check_eq("final_sel_11", int'({s1, s0}), 3);
        issue(2'b01);
        wait_done(n);
        check_eq("lat_reissue", n, G + S);
        check_eq("sel_01", int'({s1, s0}), 1);

        // Freeze for five edges mid-switch delays completion by five.
        issue(2'b10);
        step();
        tst_override = 1'b1;
        repeat (5) step();
        tst_override = 1'b0;
        wait_done(n);
        check_eq("lat_freeze", n, G + S - 1);

        // Reset in the middle of a switch.
        issue(2'b11);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_gate", int'(ck_gate_en), 1);
        check_eq("midrst_sel", int'({s1, s0}), int'(RSEL));
        step();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            tst_override = ($urandom_range(0, 9) == 0);
            sel_req_vld  = ($urandom_range(0, 2) == 0);
            sel_req      = 2'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
